// File: rtl/reg_bank_pkg.sv
// Shared FunSel encodings and width helpers for the parameterised register bank.
package reg_bank_pkg;

    localparam int unsigned FS_W = 4;

    localparam logic [FS_W-1:0] FS_DEC  = 4'b0000;
    localparam logic [FS_W-1:0] FS_INC  = 4'b0001;
    localparam logic [FS_W-1:0] FS_LOAD = 4'b0010;
    localparam logic [FS_W-1:0] FS_CLR  = 4'b0011;
    localparam logic [FS_W-1:0] FS_LDLO = 4'b0100;
    localparam logic [FS_W-1:0] FS_WRLO = 4'b0101;
    localparam logic [FS_W-1:0] FS_WRHI = 4'b0110;
    localparam logic [FS_W-1:0] FS_LDSX = 4'b0111;
    localparam logic [FS_W-1:0] FS_WRLN = 4'b1000;
    localparam logic [FS_W-1:0] FS_SHL  = 4'b1001;
    localparam logic [FS_W-1:0] FS_SHR  = 4'b1010;
    localparam logic [FS_W-1:0] FS_ASR  = 4'b1011;
    localparam logic [FS_W-1:0] FS_ROL  = 4'b1100;
    localparam logic [FS_W-1:0] FS_ROR  = 4'b1101;
    localparam logic [FS_W-1:0] FS_SINC = 4'b1110;
    localparam logic [FS_W-1:0] FS_SDEC = 4'b1111;

    // Select-field width that never collapses to zero bits.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_slice.sv
// One bank register with its sticky wrap flag; applies FunSel when enabled.
module reg_bank_slice
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned NUM_LANES = WIDTH / LANE_W,
    parameter int unsigned LS_W      = sel_width(NUM_LANES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic [FS_W-1:0]  funsel_i,
    input  logic [LS_W-1:0]  lane_sel_i,
    input  logic             en_i,
    input  logic             flag_clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]  q_q, q_d;
    logic              wrap_q, wrap_d;
    logic              wrap_evt;
    logic [LANE_W-1:0] lo;

    assign lo = data_i[LANE_W-1:0];

    always_comb begin
        q_d      = q_q;
        wrap_evt = 1'b0;
        if (en_i) begin
            case (funsel_i)
                FS_DEC: begin
                    q_d      = q_q - ONE;
                    wrap_evt = (q_q == '0);
                end
                FS_INC: begin
                    q_d      = q_q + ONE;
                    wrap_evt = (q_q == '1);
                end
                FS_LOAD: q_d = data_i;
                FS_CLR:  q_d = '0;
                FS_LDLO: q_d = {{(WIDTH-LANE_W){1'b0}}, lo};
                FS_WRLO: q_d[LANE_W-1:0] = lo;
                FS_WRHI: q_d[WIDTH-1 -: LANE_W] = lo;
                FS_LDSX: q_d = {{(WIDTH-LANE_W){lo[LANE_W-1]}}, lo};
                // Out-of-range lane selects match no iteration and leave the register untouched.
                FS_WRLN: begin
                    for (int unsigned l = 0; l < NUM_LANES; l++) begin
                        if (lane_sel_i == LS_W'(l)) q_d[l*LANE_W +: LANE_W] = lo;
                    end
                end
                FS_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
                FS_SHR:  q_d = {1'b0, q_q[WIDTH-1:1]};
                FS_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                FS_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                FS_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                FS_SINC: if (q_q != '1) q_d = q_q + ONE;
                FS_SDEC: if (q_q != '0) q_d = q_q - ONE;
                default: q_d = q_q;
            endcase
        end
        // A wrap in the same cycle as a clear keeps the flag set.
        wrap_d = (wrap_q & ~flag_clr_i) | wrap_evt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/param_register_bank.sv
// Bank of NUM_REGS lane-writable registers sharing one write bus, with two combinational read ports.
module param_register_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned NUM_REGS  = 4,
    localparam int unsigned NUM_LANES = WIDTH / LANE_W,
    localparam int unsigned LS_W      = sel_width(NUM_LANES),
    localparam int unsigned RS_W      = sel_width(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    I,
    input  logic [FS_W-1:0]     FunSel,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [LS_W-1:0]     LaneSel,
    input  logic                FlagClr,
    input  logic [RS_W-1:0]     OutASel,
    input  logic [RS_W-1:0]     OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic [NUM_REGS-1:0] Wrap
);

    logic [WIDTH-1:0] q [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_slice
        reg_bank_slice #(
            .WIDTH     (WIDTH),
            .LANE_W    (LANE_W),
            .NUM_LANES (NUM_LANES),
            .LS_W      (LS_W)
        ) u_slice (
            .clk_i      (Clock),
            .rst_ni     (Reset),
            .data_i     (I),
            .funsel_i   (FunSel),
            .lane_sel_i (LaneSel),
            .en_i       (RegSel[k]),
            .flag_clr_i (FlagClr),
            .q_o        (q[k]),
            .wrap_o     (Wrap[k])
        );
    end

    // Selects beyond the last register match nothing and read as zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (OutASel == RS_W'(k)) OutA = q[k];
            if (OutBSel == RS_W'(k)) OutB = q[k];
        end
    end

endmodule

// File: tb/tb_param_register_bank.sv
// Directed-vector bench for param_register_bank (5-register build) with a queue-based scoreboard.
module tb_param_register_bank;

    localparam int unsigned NR = 5;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [15:0]   I;
    logic [3:0]    FunSel;
    logic [NR-1:0] RegSel;
    logic [0:0]    LaneSel;
    logic          FlagClr;
    logic [2:0]    OutASel;
    logic [2:0]    OutBSel;
    logic [15:0]   OutA;
    logic [15:0]   OutB;
    logic [NR-1:0] Wrap;

    param_register_bank #(
        .WIDTH    (16),
        .LANE_W   (8),
        .NUM_REGS (NR)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .LaneSel (LaneSel),
        .FlagClr (FlagClr),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB),
        .Wrap    (Wrap)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        int          due;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  w;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string field, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    // Monitor: compares every entry due this cycle, half a period after the edge.
    always @(negedge Clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "OutA", OutA, e.a);
            cmp(e.name, "OutB", OutB, e.b);
            cmp(e.name, "Wrap", {11'd0, Wrap}, {11'd0, e.w});
        end
    end

    task automatic step(input logic [4:0] rs, input logic [3:0] fs, input logic [15:0] d,
                        input logic ls, input logic fc);
        @(posedge Clock);
        #2;
        RegSel  = rs;
        FunSel  = fs;
        I       = d;
        LaneSel = ls;
        FlagClr = fc;
    endtask

    task automatic chk_now(input string nm, input logic [2:0] as, input logic [2:0] bs,
                           input logic [15:0] a, input logic [15:0] b, input logic [4:0] w);
        OutASel = as;
        OutBSel = bs;
        sb.push_back('{nm, cyc, a, b, w});
    endtask

    task automatic observe(input string nm, input logic [2:0] as, input logic [2:0] bs,
                           input logic [15:0] a, input logic [15:0] b, input logic [4:0] w);
        @(posedge Clock);
        #2;
        RegSel  = '0;
        FlagClr = 1'b0;
        chk_now(nm, as, bs, a, b, w);
    endtask

    initial begin
        Reset   = 1'b0;
        FunSel  = 4'b0010;
        I       = 16'hBEEF;
        RegSel  = '1;
        LaneSel = 1'b0;
        FlagClr = 1'b0;
        OutASel = 3'd0;
        OutBSel = 3'd1;

        repeat (2) @(posedge Clock);
        #2 chk_now("rst_r0r1", 0, 1, 16'h0000, 16'h0000, 5'b00000);
        @(posedge Clock);
        #2 chk_now("rst_r2r3", 2, 3, 16'h0000, 16'h0000, 5'b00000);
        @(posedge Clock);
        #2 chk_now("rst_r4", 4, 4, 16'h0000, 16'h0000, 5'b00000);
        @(posedge Clock);
        #2;
        RegSel = '0;
        Reset  = 1'b1;

        step(5'b00001, 4'b0010, 16'h00FF, 0, 0);
        observe("r0_load", 0, 1, 16'h00FF, 16'h0000, 5'b00000);
        step(5'b00001, 4'b0001, 16'h0000, 0, 0);
        observe("r0_inc", 0, 0, 16'h0100, 16'h0100, 5'b00000);

        step(5'b00010, 4'b0010, 16'hFFFF, 0, 0);
        observe("r1_load", 1, 0, 16'hFFFF, 16'h0100, 5'b00000);
        step(5'b00010, 4'b0001, 16'h0000, 0, 1);
        observe("r1_wrap_vs_clr", 1, 0, 16'h0000, 16'h0100, 5'b00010);
        step(5'b00000, 4'b0000, 16'h0000, 0, 1);
        observe("flagclr", 1, 1, 16'h0000, 16'h0000, 5'b00000);
        step(5'b00010, 4'b0000, 16'h0000, 0, 0);
        observe("r1_dec_wrap", 1, 0, 16'hFFFF, 16'h0100, 5'b00010);
        step(5'b00000, 4'b0000, 16'h0000, 0, 1);
        observe("flagclr2", 1, 0, 16'hFFFF, 16'h0100, 5'b00000);

        step(5'b00100, 4'b0010, 16'h1234, 0, 0);
        observe("r2_load", 2, 1, 16'h1234, 16'hFFFF, 5'b00000);
        step(5'b00100, 4'b1000, 16'h00AB, 1, 0);
        observe("r2_lane1", 2, 2, 16'hAB34, 16'hAB34, 5'b00000);
        step(5'b00100, 4'b0111, 16'h0080, 1, 0);
        observe("r2_sext", 2, 0, 16'hFF80, 16'h0100, 5'b00000);
        step(5'b00100, 4'b1000, 16'h11CD, 0, 0);
        observe("r2_lane0", 2, 0, 16'hFFCD, 16'h0100, 5'b00000);
        step(5'b00100, 4'b0100, 16'h12F0, 0, 0);
        observe("r2_ldlo", 2, 0, 16'h00F0, 16'h0100, 5'b00000);
        step(5'b00100, 4'b0101, 16'h9977, 0, 0);
        observe("r2_wrlo", 2, 0, 16'h0077, 16'h0100, 5'b00000);
        step(5'b00100, 4'b0110, 16'h00AA, 0, 0);
        observe("r2_wrhi", 2, 0, 16'hAA77, 16'h0100, 5'b00000);

        step(5'b01000, 4'b0010, 16'h8001, 0, 0);
        step(5'b01000, 4'b1011, 16'h0000, 0, 0);
        observe("r3_asr", 3, 2, 16'hC000, 16'hAA77, 5'b00000);
        step(5'b01000, 4'b0010, 16'h8001, 0, 0);
        step(5'b01000, 4'b1100, 16'h0000, 0, 0);
        observe("r3_rol", 3, 2, 16'h0003, 16'hAA77, 5'b00000);
        step(5'b01000, 4'b1101, 16'h0000, 0, 0);
        observe("r3_ror", 3, 3, 16'h8001, 16'h8001, 5'b00000);
        step(5'b01000, 4'b1001, 16'h0000, 0, 0);
        observe("r3_shl", 3, 3, 16'h0002, 16'h0002, 5'b00000);
        step(5'b01000, 4'b1010, 16'h0000, 0, 0);
        observe("r3_shr", 3, 3, 16'h0001, 16'h0001, 5'b00000);
        step(5'b01000, 4'b0010, 16'hFFFF, 0, 0);
        step(5'b01000, 4'b1110, 16'h0000, 0, 0);
        observe("r3_sinc_sat", 3, 1, 16'hFFFF, 16'hFFFF, 5'b00000);
        step(5'b01000, 4'b0011, 16'h0000, 0, 0);
        step(5'b01000, 4'b1111, 16'h0000, 0, 0);
        observe("r3_sdec_sat", 3, 3, 16'h0000, 16'h0000, 5'b00000);
        step(5'b01000, 4'b0010, 16'h7FFF, 0, 0);
        step(5'b01000, 4'b1110, 16'h0000, 0, 0);
        observe("r3_sinc", 3, 3, 16'h8000, 16'h8000, 5'b00000);
        step(5'b01000, 4'b1111, 16'h0000, 0, 0);
        observe("r3_sdec", 3, 3, 16'h7FFF, 16'h7FFF, 5'b00000);
        step(5'b01000, 4'b0010, 16'h5A5A, 0, 0);
        observe("r3_final", 3, 1, 16'h5A5A, 16'hFFFF, 5'b00000);

        step(5'b00011, 4'b0001, 16'h0000, 0, 0);
        observe("multi_inc", 0, 1, 16'h0101, 16'h0000, 5'b00010);
        step(5'b00010, 4'b0010, 16'h1357, 0, 1);
        step(5'b00101, 4'b0011, 16'hFFFF, 0, 0);
        observe("regsel_0101", 0, 2, 16'h0000, 16'h0000, 5'b00000);
        observe("held_r1r3", 1, 3, 16'h1357, 16'h5A5A, 5'b00000);
        observe("same_sel", 2, 2, 16'h0000, 16'h0000, 5'b00000);
        observe("sel_oob", 5, 7, 16'h0000, 16'h0000, 5'b00000);
        observe("sel_r4_oob6", 6, 4, 16'h0000, 16'h0000, 5'b00000);

        step(5'b00001, 4'b0010, 16'h1111, 0, 0);
        #1 Reset = 1'b0;
        chk_now("async_rst", 1, 3, 16'h0000, 16'h0000, 5'b00000);
        @(posedge Clock);
        #2 chk_now("rst_discard", 0, 0, 16'h0000, 16'h0000, 5'b00000);
        @(posedge Clock);
        #2;
        Reset  = 1'b1;
        RegSel = 5'b00001;
        FunSel = 4'b0001;
        observe("post_rst_inc", 0, 0, 16'h0001, 16'h0001, 5'b00000);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
